// File: rtl/exe_stage.sv
// Execute stage: ALU, RV32M multiply/iterative divide, branch/jump resolution, exe->mem register.
// Optional RV32M support is enabled by defining MULDIV_EN; without it ops 16-23 yield 0 and Stall_o is 0.
module exe_stage #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Src_pc_i,
  input  logic [31:0] Src_rs1_i,
  input  logic [31:0] Src_rs2_i,
  input  logic [31:0] Src_imm_i,
  input  logic [4:0]  Src_rd_i,
  input  logic [4:0]  Inst_alu_op_i,
  input  logic        Inst_a_sel_i,
  input  logic        Inst_b_sel_i,
  input  logic        Inst_branch_i,
  input  logic [2:0]  Inst_br_funct3_i,
  input  logic [1:0]  Inst_jump_i,
  input  logic [1:0]  Inst_mem_out_sel_i,
  input  logic [2:0]  Inst_mem_rd_sel_i,
  input  logic [1:0]  Inst_mem_we_i,
  input  logic        Inst_wb_we_i,
  input  logic [7:0]  Id_tracker,
  output logic        Stall_o,
  output logic        Redirect_o,
  output logic [31:0] Redirect_pc_o,
  output logic [31:0] Src_pc_o,
  output logic [31:0] Src_alu_o,
  output logic [31:0] Src_rs2_o,
  output logic [31:0] Src_imm_o,
  output logic [4:0]  Src_rd_o,
  output logic [1:0]  Inst_mem_out_sel_o,
  output logic [2:0]  Inst_mem_rd_sel_o,
  output logic [1:0]  Inst_mem_we_o,
  output logic        Inst_wb_we_o,
  output logic [7:0]  Exe_tracker
);

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLL    = 5'd2;
  localparam logic [4:0] OP_SLT    = 5'd3;
  localparam logic [4:0] OP_SLTU   = 5'd4;
  localparam logic [4:0] OP_XOR    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_OR     = 5'd8;
  localparam logic [4:0] OP_AND    = 5'd9;
  localparam logic [4:0] OP_PASSB  = 5'd10;
  localparam logic [4:0] OP_MUL    = 5'd16;
  localparam logic [4:0] OP_MULH   = 5'd17;
  localparam logic [4:0] OP_MULHSU = 5'd18;
  localparam logic [4:0] OP_MULHU  = 5'd19;
  localparam logic [4:0] OP_DIV    = 5'd20;
  localparam logic [4:0] OP_DIVU   = 5'd21;
  localparam logic [4:0] OP_REM    = 5'd22;
  localparam logic [4:0] OP_REMU   = 5'd23;

  logic [31:0] op_a, op_b;
  logic [4:0]  shamt;
  logic [31:0] alu_res;
  logic [31:0] md_res;
  logic [31:0] exe_res;
  logic        br_cond;

  assign op_a  = Inst_a_sel_i ? Src_pc_i  : Src_rs1_i;
  assign op_b  = Inst_b_sel_i ? Src_imm_i : Src_rs2_i;
  assign shamt = op_b[4:0];

  always_comb begin
    alu_res = 32'd0;
    case (Inst_alu_op_i)
      OP_ADD:   alu_res = op_a + op_b;
      OP_SUB:   alu_res = op_a - op_b;
      OP_SLL:   alu_res = op_a << shamt;
      OP_SLT:   alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      OP_SLTU:  alu_res = {31'd0, op_a < op_b};
      OP_XOR:   alu_res = op_a ^ op_b;
      OP_SRL:   alu_res = op_a >> shamt;
      OP_SRA:   alu_res = $signed(op_a) >>> shamt;
      OP_OR:    alu_res = op_a | op_b;
      OP_AND:   alu_res = op_a & op_b;
      OP_PASSB: alu_res = op_b;
      default:  alu_res = 32'd0;
    endcase
  end

  // Branch condition always uses the raw register operands, independent of operand muxing.
  always_comb begin
    br_cond = 1'b0;
    case (Inst_br_funct3_i)
      3'd0:    br_cond = Src_rs1_i == Src_rs2_i;
      3'd1:    br_cond = Src_rs1_i != Src_rs2_i;
      3'd4:    br_cond = $signed(Src_rs1_i) <  $signed(Src_rs2_i);
      3'd5:    br_cond = $signed(Src_rs1_i) >= $signed(Src_rs2_i);
      3'd6:    br_cond = Src_rs1_i <  Src_rs2_i;
      3'd7:    br_cond = Src_rs1_i >= Src_rs2_i;
      default: br_cond = 1'b0;
    endcase
  end

`ifdef MULDIV_EN
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_t;

  logic               mul_a_sg, mul_b_sg;
  logic signed [32:0] mul_a, mul_b;
  logic signed [63:0] mul_p;

  assign mul_a_sg = (Inst_alu_op_i == OP_MULH) || (Inst_alu_op_i == OP_MULHSU);
  assign mul_b_sg = (Inst_alu_op_i == OP_MULH);
  assign mul_a    = {mul_a_sg & op_a[31], op_a};
  assign mul_b    = {mul_b_sg & op_b[31], op_b};
  assign mul_p    = mul_a * mul_b;

  div_state_t  div_state;
  logic [5:0]  div_count;
  logic [31:0] div_rem, div_quo, div_dvsr;
  logic        div_neg_q, div_neg_r;
  logic        is_div, div_signed, div_is_rem, div_by_zero, div_ovf, div_start;
  logic        sign_a, sign_b;
  logic [32:0] rem_sh, rem_diff;
  logic [31:0] q_final, r_final;

  assign is_div      = (Inst_alu_op_i >= OP_DIV) && (Inst_alu_op_i <= OP_REMU);
  assign div_signed  = (Inst_alu_op_i == OP_DIV) || (Inst_alu_op_i == OP_REM);
  assign div_is_rem  = (Inst_alu_op_i == OP_REM) || (Inst_alu_op_i == OP_REMU);
  assign div_by_zero = op_b == 32'd0;
  assign div_ovf     = div_signed && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
  assign sign_a      = div_signed & op_a[31];
  assign sign_b      = div_signed & op_b[31];
  assign div_start   = ~Reset && (div_state == S_IDLE) && is_div && (Id_tracker != 8'd0)
                       && !div_by_zero && !div_ovf;
  assign Stall_o     = div_start || (~Reset && (div_state == S_BUSY));

  // Restoring step: shift the next dividend bit in, keep the difference if non-negative.
  assign rem_sh   = {div_rem, div_quo[31]};
  assign rem_diff = rem_sh - {1'b0, div_dvsr};
  assign q_final  = div_neg_q ? -div_quo : div_quo;
  assign r_final  = div_neg_r ? -div_rem : div_rem;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_state <= S_IDLE;
      div_count <= 6'd0;
      div_rem   <= 32'd0;
      div_quo   <= 32'd0;
      div_dvsr  <= 32'd0;
      div_neg_q <= 1'b0;
      div_neg_r <= 1'b0;
    end else begin
      case (div_state)
        S_IDLE: if (div_start) begin
          div_state <= S_BUSY;
          div_count <= DIV_CYCLES[5:0];
          div_rem   <= 32'd0;
          div_quo   <= sign_a ? -op_a : op_a;
          div_dvsr  <= sign_b ? -op_b : op_b;
          div_neg_q <= sign_a ^ sign_b;
          div_neg_r <= sign_a;
        end
        S_BUSY: begin
          if (!rem_diff[32]) begin
            div_rem <= rem_diff[31:0];
            div_quo <= {div_quo[30:0], 1'b1};
          end else begin
            div_rem <= rem_sh[31:0];
            div_quo <= {div_quo[30:0], 1'b0};
          end
          div_count <= div_count - 6'd1;
          if (div_count == 6'd1) div_state <= S_DONE;
        end
        S_DONE:  div_state <= S_IDLE;
        default: div_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    md_res = 32'd0;
    case (Inst_alu_op_i)
      OP_MUL:                     md_res = mul_p[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: md_res = mul_p[63:32];
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
        if (div_state == S_DONE)  md_res = div_is_rem ? r_final : q_final;
        else if (div_by_zero)     md_res = div_is_rem ? op_a : 32'hFFFF_FFFF;
        else if (div_ovf)         md_res = div_is_rem ? 32'd0 : 32'h8000_0000;
        else                      md_res = 32'd0;
      end
      default:                    md_res = 32'd0;
    endcase
  end
`else
  assign Stall_o = 1'b0;
  assign md_res  = 32'd0;
`endif

  assign exe_res = Inst_alu_op_i[4] ? md_res : alu_res;

  assign Redirect_o    = ((Inst_branch_i & br_cond) | (Inst_jump_i != 2'd0))
                         & (Id_tracker != 8'd0) & ~Stall_o;
  assign Redirect_pc_o = (Inst_jump_i == 2'd2) ? ((Src_rs1_i + Src_imm_i) & ~32'd1)
                                               : (Src_pc_i + Src_imm_i);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Src_pc_o           <= 32'd0;
      Src_alu_o          <= 32'd0;
      Src_rs2_o          <= 32'd0;
      Src_imm_o          <= 32'd0;
      Src_rd_o           <= 5'd0;
      Inst_mem_out_sel_o <= 2'd0;
      Inst_mem_rd_sel_o  <= 3'd0;
      Inst_mem_we_o      <= 2'd0;
      Inst_wb_we_o       <= 1'b0;
      Exe_tracker        <= 8'd0;
    end else if (Stall_o) begin
      Inst_mem_we_o <= 2'd0;
      Inst_wb_we_o  <= 1'b0;
      Exe_tracker   <= 8'd0;
    end else begin
      Src_pc_o           <= Src_pc_i;
      Src_alu_o          <= exe_res;
      Src_rs2_o          <= Src_rs2_i;
      Src_imm_o          <= Src_imm_i;
      Src_rd_o           <= Src_rd_i;
      Inst_mem_out_sel_o <= Inst_mem_out_sel_i;
      Inst_mem_rd_sel_o  <= Inst_mem_rd_sel_i;
      Inst_mem_we_o      <= Inst_mem_we_i;
      Inst_wb_we_o       <= Inst_wb_we_i;
      Exe_tracker        <= Id_tracker;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage; RV32M expectations follow whether MULDIV_EN is defined.
module tb_exe_stage;
`ifdef MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] Src_pc_i, Src_rs1_i, Src_rs2_i, Src_imm_i;
  logic [4:0]  Src_rd_i, Inst_alu_op_i;
  logic        Inst_a_sel_i, Inst_b_sel_i, Inst_branch_i, Inst_wb_we_i;
  logic [2:0]  Inst_br_funct3_i, Inst_mem_rd_sel_i;
  logic [1:0]  Inst_jump_i, Inst_mem_out_sel_i, Inst_mem_we_i;
  logic [7:0]  Id_tracker;
  logic        Stall_o, Redirect_o, Inst_wb_we_o;
  logic [31:0] Redirect_pc_o, Src_pc_o, Src_alu_o, Src_rs2_o, Src_imm_o;
  logic [4:0]  Src_rd_o;
  logic [1:0]  Inst_mem_out_sel_o, Inst_mem_we_o;
  logic [2:0]  Inst_mem_rd_sel_o;
  logic [7:0]  Exe_tracker;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  exe_stage dut (
    .Clk(Clk), .Reset(Reset),
    .Src_pc_i(Src_pc_i), .Src_rs1_i(Src_rs1_i), .Src_rs2_i(Src_rs2_i), .Src_imm_i(Src_imm_i),
    .Src_rd_i(Src_rd_i), .Inst_alu_op_i(Inst_alu_op_i), .Inst_a_sel_i(Inst_a_sel_i),
    .Inst_b_sel_i(Inst_b_sel_i), .Inst_branch_i(Inst_branch_i), .Inst_br_funct3_i(Inst_br_funct3_i),
    .Inst_jump_i(Inst_jump_i), .Inst_mem_out_sel_i(Inst_mem_out_sel_i),
    .Inst_mem_rd_sel_i(Inst_mem_rd_sel_i), .Inst_mem_we_i(Inst_mem_we_i),
    .Inst_wb_we_i(Inst_wb_we_i), .Id_tracker(Id_tracker),
    .Stall_o(Stall_o), .Redirect_o(Redirect_o), .Redirect_pc_o(Redirect_pc_o),
    .Src_pc_o(Src_pc_o), .Src_alu_o(Src_alu_o), .Src_rs2_o(Src_rs2_o), .Src_imm_o(Src_imm_o),
    .Src_rd_o(Src_rd_o), .Inst_mem_out_sel_o(Inst_mem_out_sel_o),
    .Inst_mem_rd_sel_o(Inst_mem_rd_sel_o), .Inst_mem_we_o(Inst_mem_we_o),
    .Inst_wb_we_o(Inst_wb_we_o), .Exe_tracker(Exe_tracker)
  );

  task automatic set_nop();
    Src_pc_i = 0; Src_rs1_i = 0; Src_rs2_i = 0; Src_imm_i = 0; Src_rd_i = 0;
    Inst_alu_op_i = 0; Inst_a_sel_i = 0; Inst_b_sel_i = 0; Inst_branch_i = 0;
    Inst_br_funct3_i = 0; Inst_jump_i = 0; Inst_mem_out_sel_i = 0; Inst_mem_rd_sel_i = 0;
    Inst_mem_we_i = 0; Inst_wb_we_i = 0; Id_tracker = 0;
  endtask

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic set_op(input logic [4:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [7:0] trk);
    set_nop();
    Inst_alu_op_i = op; Src_rs1_i = rs1; Src_rs2_i = rs2; Id_tracker = trk; Inst_wb_we_i = 1;
  endtask

  task automatic test_reset();
    set_op(5'd0, 32'h11, 32'h22, 8'h33);
    Inst_mem_we_i = 2'd3; Src_pc_i = 32'h44;
    Reset = 1'b1;
    tick(); tick();
    total++; if (Src_alu_o !== 32'd0) begin bad++; $display("FAIL reset_alu got=%h exp=0", Src_alu_o); end
    total++; if (Exe_tracker !== 8'd0) begin bad++; $display("FAIL reset_tracker got=%h exp=0", Exe_tracker); end
    total++; if ({Src_pc_o, Src_rs2_o, Inst_mem_we_o, Inst_wb_we_o} !== 67'd0) begin
      bad++; $display("FAIL reset_fields got=%h/%h/%h/%b exp=0", Src_pc_o, Src_rs2_o, Inst_mem_we_o, Inst_wb_we_o); end
    total++; if (Stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", Stall_o); end
    Reset = 1'b0;
    set_nop();
    tick();
  endtask

  task automatic test_add();
    set_op(5'd0, 32'h7FFF_FFFF, 32'h0000_0055, 8'd5);
    Inst_b_sel_i = 1; Src_imm_i = 32'd1; Src_pc_i = 32'h200; Src_rd_i = 5'd9;
    Inst_mem_rd_sel_i = 3'd5; Inst_mem_out_sel_i = 2'd2;
    #1;
    total++; if (Stall_o !== 1'b0) begin bad++; $display("FAIL add_stall got=%b exp=0", Stall_o); end
    tick();
    total++; if (Src_alu_o !== 32'h8000_0000) begin bad++; $display("FAIL add_result got=%h exp=80000000", Src_alu_o); end
    total++; if (Exe_tracker !== 8'd5) begin bad++; $display("FAIL add_tracker got=%h exp=05", Exe_tracker); end
    total++; if ({Src_pc_o, Src_rs2_o, Src_imm_o, Src_rd_o, Inst_mem_rd_sel_o, Inst_mem_out_sel_o, Inst_wb_we_o}
                 !== {32'h200, 32'h55, 32'h1, 5'd9, 3'd5, 2'd2, 1'b1}) begin
      bad++; $display("FAIL add_passthru got=%h/%h/%h/%h/%h/%h/%b", Src_pc_o, Src_rs2_o, Src_imm_o,
                      Src_rd_o, Inst_mem_rd_sel_o, Inst_mem_out_sel_o, Inst_wb_we_o); end
  endtask

  task automatic test_alu_ops();
    set_op(5'd1, 32'd5, 32'd7, 8'd1); tick();
    total++; if (Src_alu_o !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sub got=%h exp=fffffffe", Src_alu_o); end
    set_op(5'd7, 32'h8000_0000, 32'h0000_0024, 8'd2); tick();
    total++; if (Src_alu_o !== 32'hF800_0000) begin bad++; $display("FAIL sra got=%h exp=f8000000", Src_alu_o); end
    set_op(5'd3, 32'hFFFF_FFFF, 32'd1, 8'd3); tick();
    total++; if (Src_alu_o !== 32'd1) begin bad++; $display("FAIL slt got=%h exp=1", Src_alu_o); end
    set_op(5'd4, 32'hFFFF_FFFF, 32'd1, 8'd4); tick();
    total++; if (Src_alu_o !== 32'd0) begin bad++; $display("FAIL sltu got=%h exp=0", Src_alu_o); end
    set_op(5'd2, 32'h0000_0003, 32'd4, 8'd5); Inst_a_sel_i = 1; Src_pc_i = 32'h0000_0101; tick();
    total++; if (Src_alu_o !== 32'h0000_1010) begin bad++; $display("FAIL sll_pc got=%h exp=00001010", Src_alu_o); end
    set_op(5'd10, 32'h1234, 32'h5678, 8'd6); Inst_b_sel_i = 1; Src_imm_i = 32'hABCD_0000; tick();
    total++; if (Src_alu_o !== 32'hABCD_0000) begin bad++; $display("FAIL passb got=%h exp=abcd0000", Src_alu_o); end
    set_op(5'd11, 32'h1234, 32'h5678, 8'd7); tick();
    total++; if (Src_alu_o !== 32'd0) begin bad++; $display("FAIL bad_op got=%h exp=0", Src_alu_o); end
  endtask

  task automatic test_mul();
    set_op(5'd16, 32'd3, 32'hFFFF_FFFE, 8'd1); tick();
    total++; if (Src_alu_o !== (MD ? 32'hFFFF_FFFA : 32'd0)) begin bad++; $display("FAIL mul got=%h", Src_alu_o); end
    set_op(5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd2); tick();
    total++; if (Src_alu_o !== 32'd0) begin bad++; $display("FAIL mulh got=%h exp=0", Src_alu_o); end
    set_op(5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd3); tick();
    total++; if (Src_alu_o !== (MD ? 32'hFFFF_FFFF : 32'd0)) begin bad++; $display("FAIL mulhsu got=%h", Src_alu_o); end
    set_op(5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd4); tick();
    total++; if (Src_alu_o !== (MD ? 32'hFFFF_FFFE : 32'd0)) begin bad++; $display("FAIL mulhu got=%h", Src_alu_o); end
  endtask

  task automatic test_branch();
    set_op(5'd0, 32'hFFFF_FFFF, 32'd1, 8'd1);
    Inst_branch_i = 1; Inst_br_funct3_i = 3'd4; Src_pc_i = 32'h100; Src_imm_i = 32'h20; #1;
    total++; if ({Redirect_o, Redirect_pc_o} !== {1'b1, 32'h120}) begin
      bad++; $display("FAIL blt got=%b/%h exp=1/00000120", Redirect_o, Redirect_pc_o); end
    Inst_br_funct3_i = 3'd6; #1;
    total++; if (Redirect_o !== 1'b0) begin bad++; $display("FAIL bltu got=%b exp=0", Redirect_o); end
    Inst_br_funct3_i = 3'd2; Src_rs2_i = 32'hFFFF_FFFF; #1;
    total++; if (Redirect_o !== 1'b0) begin bad++; $display("FAIL funct3_2 got=%b exp=0", Redirect_o); end
    Inst_br_funct3_i = 3'd7; #1;
    total++; if (Redirect_o !== 1'b1) begin bad++; $display("FAIL bgeu_eq got=%b exp=1", Redirect_o); end
    Inst_branch_i = 0; Inst_jump_i = 2'd1; Id_tracker = 8'd0; #1;
    total++; if (Redirect_o !== 1'b0) begin bad++; $display("FAIL jal_bubble got=%b exp=0", Redirect_o); end
    tick();
  endtask

  task automatic test_jalr();
    set_op(5'd0, 32'h1003, 32'd0, 8'd8);
    Inst_jump_i = 2'd2; Src_imm_i = 32'd4; Src_pc_i = 32'h500; #1;
    total++; if ({Redirect_o, Redirect_pc_o} !== {1'b1, 32'h1006}) begin
      bad++; $display("FAIL jalr got=%b/%h exp=1/00001006", Redirect_o, Redirect_pc_o); end
    tick();
  endtask

  task automatic run_div(input logic [4:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] exp_res, input int exp_stall, input string name);
    int  stall_cyc = 0;
    logic bubble_ok = 1'b1;
    set_op(op, rs1, rs2, 8'd9);
    Inst_mem_we_i = 2'd1;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (!Stall_o) break;
      stall_cyc++;
      tick();
      if (Exe_tracker !== 8'd0 || Inst_wb_we_o !== 1'b0 || Inst_mem_we_o !== 2'd0) bubble_ok = 1'b0;
    end
    total++; if (stall_cyc != exp_stall) begin bad++; $display("FAIL %s_stall_cycles got=%0d exp=%0d", name, stall_cyc, exp_stall); end
    total++; if (!bubble_ok) begin bad++; $display("FAIL %s_bubbles got=non-bubble exp=bubble", name); end
    tick();
    total++; if ({Src_alu_o, Exe_tracker} !== {exp_res, 8'd9}) begin
      bad++; $display("FAIL %s_result got=%h/%h exp=%h/09", name, Src_alu_o, Exe_tracker, exp_res); end
  endtask

  task automatic test_div();
    run_div(5'd20, 32'hFFFF_FFF9, 32'd2, MD ? 32'hFFFF_FFFD : 32'd0, MD ? 33 : 0, "div");
    run_div(5'd22, 32'hFFFF_FFF9, 32'd2, MD ? 32'hFFFF_FFFF : 32'd0, MD ? 33 : 0, "rem");
    run_div(5'd21, 32'd100, 32'd7, MD ? 32'd14 : 32'd0, MD ? 33 : 0, "divu");
    run_div(5'd21, 32'h1234, 32'd0, MD ? 32'hFFFF_FFFF : 32'd0, 0, "divu0");
    run_div(5'd23, 32'h1234, 32'd0, MD ? 32'h1234 : 32'd0, 0, "remu0");
    run_div(5'd20, 32'h8000_0000, 32'hFFFF_FFFF, MD ? 32'h8000_0000 : 32'd0, 0, "div_ovf");
    set_op(5'd20, 32'd50, 32'd5, 8'd0); #1;
    total++; if (Stall_o !== 1'b0) begin bad++; $display("FAIL div_bubble_stall got=%b exp=0", Stall_o); end
    tick();
  endtask

  task automatic test_reset_mid_div();
    set_op(5'd20, 32'd100, 32'd3, 8'd4);
    #1;
    repeat (11) tick();
    total++; if (Stall_o !== MD) begin bad++; $display("FAIL busy_stall got=%b exp=%b", Stall_o, MD); end
    set_nop();
    Reset = 1'b1;
    tick();
    total++; if ({Stall_o, Src_alu_o, Exe_tracker, Src_pc_o, Src_rs2_o} !== 105'd0) begin
      bad++; $display("FAIL reset_abort got=%b/%h/%h/%h/%h exp=0", Stall_o, Src_alu_o, Exe_tracker, Src_pc_o, Src_rs2_o); end
    Reset = 1'b0;
    set_op(5'd0, 32'd2, 32'd3, 8'd7); #1;
    total++; if (Stall_o !== 1'b0) begin bad++; $display("FAIL post_reset_stall got=%b exp=0", Stall_o); end
    tick();
    total++; if ({Src_alu_o, Exe_tracker} !== {32'd5, 8'd7}) begin
      bad++; $display("FAIL post_reset_add got=%h/%h exp=00000005/07", Src_alu_o, Exe_tracker); end
  endtask

  task automatic test_back_to_back();
    set_op(5'd8, 32'hF0, 32'h0F, 8'd10); tick();
    total++; if ({Src_alu_o, Exe_tracker} !== {32'hFF, 8'd10}) begin bad++; $display("FAIL b2b_or got=%h/%h", Src_alu_o, Exe_tracker); end
    set_op(5'd9, 32'hF0, 32'h3C, 8'd11); tick();
    total++; if ({Src_alu_o, Exe_tracker} !== {32'h30, 8'd11}) begin bad++; $display("FAIL b2b_and got=%h/%h", Src_alu_o, Exe_tracker); end
    set_op(5'd5, 32'hF0, 32'h3C, 8'd12); tick();
    total++; if ({Src_alu_o, Exe_tracker} !== {32'hCC, 8'd12}) begin bad++; $display("FAIL b2b_xor got=%h/%h", Src_alu_o, Exe_tracker); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    set_nop();
    Reset = 1'b1;
    @(negedge Clk);
    test_reset();
    test_add();
    test_alu_ops();
    test_mul();
    test_branch();
    test_jalr();
    test_div();
    test_reset_mid_div();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
